// File: rtl/avalon_register_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_register_arbiter
//
// Shares one fixed-latency Avalon register adapter port between REQUESTERS
// independent masters. A round-robin arbiter picks at most one command per
// cycle and registers it onto the adapter port. Every issued read carries its
// requester ID through a LATENCY-deep tag pipeline so that the returning read
// data is steered only to the master that asked for it.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset          : asynchronous, active-high
//   req_read       : per-master read request, held until acked
//   req_write      : per-master write request, held until acked
//   req_address    : per-master register address, packed, master 0 in LSBs
//   req_data       : per-master write data, packed, master 0 in LSBs
//   req_ack        : one-hot, combinational, command accepted this cycle
//   resp_valid     : one-hot, registered, read data belongs to that master
//   resp_data      : read data, meaningful while resp_valid is non-zero
//   m_read         : adapter read strobe (registered)
//   m_write        : adapter write strobe (registered)
//   m_address      : adapter register address (registered)
//   m_data_in      : adapter write data (registered)
//   m_read_valid   : adapter read data valid, LATENCY cycles after m_read
//   m_data_out     : adapter read data
//   protocol_error : sticky flag, m_read_valid arrived with no read in flight
//
// Request handshake
//   req_read/req_write act as "valid" and req_ack as "ready": a command moves
//   in the cycle where a master's request and its req_ack bit are both high,
//   and it is captured on that rising edge. The master keeps address/data
//   stable while requesting and drops or changes its request after the edge.
//   The adapter side has no back-pressure: it takes one command per cycle.
// -----------------------------------------------------------------------------
module avalon_register_arbiter #(
  parameter int REQUESTERS   = 2,
  parameter int REGS         = 4,
  parameter int LATENCY      = 1,
  parameter int ADDRESSWIDTH = $clog2(REGS),
  parameter int IDWIDTH      = $clog2(REQUESTERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            req_read,
  input  logic [REQUESTERS-1:0]            req_write,
  input  logic [REQUESTERS*ADDRESSWIDTH-1:0] req_address,
  input  logic [REQUESTERS*32-1:0]         req_data,
  output logic [REQUESTERS-1:0]            req_ack,
  output logic [REQUESTERS-1:0]            resp_valid,
  output logic [31:0]                      resp_data,
  output logic                             m_read,
  output logic                             m_write,
  output logic [ADDRESSWIDTH-1:0]          m_address,
  output logic [31:0]                      m_data_in,
  input  logic                             m_read_valid,
  input  logic [31:0]                      m_data_out,
  output logic                             protocol_error
);

  // A single requester still needs a one-bit ID/pointer so the datapath
  // keeps a legal width; it simply never leaves zero.
  localparam int ID_W = (IDWIDTH > 0) ? IDWIDTH : 1;
  localparam int LAST = LATENCY - 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]         rr_q, rr_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;
  logic [ADDRESSWIDTH-1:0] m_address_q, m_address_d;
  logic [31:0]             m_data_q, m_data_d;
  logic [ID_W-1:0]         m_id_q, m_id_d;
  logic                    tag_pend_q [LATENCY];
  logic [ID_W-1:0]         tag_id_q   [LATENCY];
  logic [REQUESTERS-1:0]   resp_valid_q, resp_valid_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic                    perr_q, perr_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [REQUESTERS-1:0]   req_any;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W:0]           cand_w;
  logic [ID_W-1:0]         cand;

  assign req_any = req_read | req_write;

  // Walk the masters starting at the pointer; the one extra bit in cand_w
  // lets the sum exceed REQUESTERS before the modulo wrap is applied.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand_w      = '0;
    cand        = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand_w = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand_w >= (ID_W+1)'(REQUESTERS)) begin
        cand_w = cand_w - (ID_W+1)'(REQUESTERS);
      end
      cand = cand_w[ID_W-1:0];
      if (!grant_valid && req_any[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Ack is suppressed while reset is asserted so no master sees a transfer
  // that the (held-in-reset) registers will never capture.
  always_comb begin
    req_ack = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      req_ack[i] = !reset && grant_valid && (grant_id == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Winner command selection
  // ---------------------------------------------------------------------------
  logic                    win_read;
  logic                    win_write;
  logic [ADDRESSWIDTH-1:0] win_address;
  logic [31:0]             win_data;

  always_comb begin
    win_read    = 1'b0;
    win_write   = 1'b0;
    win_address = '0;
    win_data    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_id == ID_W'(i)) begin
        // Write has priority: a master raising both gets one ack for the write
        // and its read is dropped.
        win_write   = req_write[i];
        win_read    = req_read[i] && !req_write[i];
        win_address = req_address[i*ADDRESSWIDTH +: ADDRESSWIDTH];
        win_data    = req_data[i*32 +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: pointer and adapter command
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_d        = rr_q;
    m_read_d    = 1'b0;
    m_write_d   = 1'b0;
    m_address_d = m_address_q;
    m_data_d    = m_data_q;
    m_id_d      = m_id_q;
    if (grant_valid) begin
      rr_d        = (grant_id == ID_W'(REQUESTERS - 1)) ? '0 : grant_id + ID_W'(1);
      m_read_d    = win_read;
      m_write_d   = win_write;
      m_address_d = win_address;
      m_data_d    = win_data;
      m_id_d      = grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: read return
  // ---------------------------------------------------------------------------
  // The tag for a read enters stage 0 one edge after m_read is launched, so
  // stage LAST holds that tag exactly in the cycle m_read_valid is due.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    perr_d       = perr_q;
    if (m_read_valid) begin
      if (tag_pend_q[LAST]) begin
        for (int i = 0; i < REQUESTERS; i++) begin
          resp_valid_d[i] = (tag_id_q[LAST] == ID_W'(i));
        end
        resp_data_d = m_data_out;
      end else begin
        perr_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q         <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_address_q  <= '0;
      m_data_q     <= '0;
      m_id_q       <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      perr_q       <= 1'b0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_pend_q[s] <= 1'b0;
        tag_id_q[s]   <= '0;
      end
    end else begin
      rr_q         <= rr_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_address_q  <= m_address_d;
      m_data_q     <= m_data_d;
      m_id_q       <= m_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      perr_q       <= perr_d;
      tag_pend_q[0] <= m_read_q;
      tag_id_q[0]   <= m_id_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_pend_q[s] <= tag_pend_q[s-1];
        tag_id_q[s]   <= tag_id_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_read         = m_read_q;
  assign m_write        = m_write_q;
  assign m_address      = m_address_q;
  assign m_data_in      = m_data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_avalon_register_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for avalon_register_arbiter with three masters, four
// registers and a one-cycle adapter. A small behavioural adapter holds the
// register file and answers reads one cycle after m_read. Inputs are driven
// just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_avalon_register_arbiter;

  localparam int R  = 3;
  localparam int AW = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [R-1:0]    req_read, req_write, req_ack, resp_valid;
  logic [R*AW-1:0] req_address;
  logic [R*32-1:0] req_data;
  logic [31:0]     resp_data, m_data_in, m_data_out;
  logic            m_read, m_write, m_read_valid, protocol_error;
  logic [AW-1:0]   m_address;

  avalon_register_arbiter #(
    .REQUESTERS (R),
    .REGS       (4),
    .LATENCY    (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_address      (m_address),
    .m_data_in      (m_data_in),
    .m_read_valid   (m_read_valid),
    .m_data_out     (m_data_out),
    .protocol_error (protocol_error)
  );

  // ---------------------------------------------------------------------------
  // Adapter model: LATENCY = 1
  // ---------------------------------------------------------------------------
  logic [31:0] regs [4];
  logic        rv_q;
  logic [31:0] dout_q;
  logic        force_rv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q    <= 1'b0;
      dout_q  <= '0;
      regs[0] <= 32'h0BAD_0000;
      regs[1] <= 32'hC0DE_0001;
      regs[2] <= 32'hA5A5_0001;
      regs[3] <= 32'h3333_0003;
    end else begin
      rv_q <= m_read;
      if (m_read)  dout_q <= regs[m_address];
      if (m_write) regs[m_address] <= m_data_in;
    end
  end

  assign m_read_valid = rv_q | force_rv;
  assign m_data_out   = dout_q;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int tests    = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int i, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [31:0] d);
    req_read[i]            = rd;
    req_write[i]           = wr;
    req_address[i*AW +: AW] = a;
    req_data[i*32 +: 32]    = d;
  endtask

  task automatic idle();
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_data    = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    idle();
    force_rv = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int          exp_id [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  logic [R-1:0] exp_ack;

  initial begin
    idle();
    force_rv = 1'b0;

    // 1: ack held off during reset, then quiet outputs for 10 cycles.
    reset = 1'b1;
    @(negedge clk);
    req_read = 3'b111;
    #1;
    check("t1_ack_in_reset", 32'(req_ack), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("t1_ctrl_idle", {19'b0, req_ack, resp_valid, m_read, m_write, m_address, protocol_error}, 32'h0);
      check("t1_data_idle", resp_data | m_data_in, 32'h0);
    end

    // 2: single read from master 0, addr 2; response at t+3.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0);
    #1 check("t2_ack", 32'(req_ack), 32'h1);
    @(negedge clk); idle(); #1;
    check("t2_m_read", 32'(m_read), 32'h1);
    check("t2_m_address", 32'(m_address), 32'h2);
    check("t2_ack_drop", 32'(req_ack), 32'h0);
    @(negedge clk); #1;
    check("t2_resp_early", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("t2_resp_valid", 32'(resp_valid), 32'h1);
    check("t2_resp_data", resp_data, 32'hA5A5_0001);
    @(negedge clk); #1;
    check("t2_resp_pulse", 32'(resp_valid), 32'h0);

    // 3: masters 0 and 1 read together; granted 0 then 1.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'd0, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd1, 32'h0);
    #1 check("t3_ack0", 32'(req_ack), 32'h1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0);
    #1;
    check("t3_ack1", 32'(req_ack), 32'h2);
    check("t3_m_addr0", 32'(m_address), 32'h0);
    @(negedge clk); idle(); #1;
    check("t3_m_read1", 32'(m_read), 32'h1);
    check("t3_m_addr1", 32'(m_address), 32'h1);
    @(negedge clk); #1;
    check("t3_resp0_valid", 32'(resp_valid), 32'h1);
    check("t3_resp0_data", resp_data, 32'h0BAD_0000);
    @(negedge clk); #1;
    check("t3_resp1_valid", 32'(resp_valid), 32'h2);
    check("t3_resp1_data", resp_data, 32'hC0DE_0001);
    @(negedge clk); #1;
    check("t3_resp_done", 32'(resp_valid), 32'h0);

    // 4: three masters write continuously; fair rotation 0,1,2,...
    do_reset();
    for (int i = 0; i < R; i++) drive(i, 1'b0, 1'b1, AW'(i), 32'hD0 + 32'(i));
    for (int n = 0; n < 9; n++) begin
      exp_ack = 3'b001;
      exp_ack = exp_ack << exp_id[n];
      #1 check("t4_grant", 32'(req_ack), 32'(exp_ack));
      @(negedge clk);
      #1;
      check("t4_m_write", 32'(m_write), 32'h1);
      check("t4_m_data", m_data_in, 32'hD0 + 32'(exp_id[n]));
    end
    idle();

    // 4b: read+write on one master: write wins, single ack, no response.
    // Pointer is back at 0 after the last grant to master 2.
    drive(2, 1'b1, 1'b1, 2'd1, 32'hBEEF_0002);
    #1 check("t4b_ack", 32'(req_ack), 32'h4);
    @(negedge clk); idle(); #1;
    check("t4b_m_write", 32'(m_write), 32'h1);
    check("t4b_m_read", 32'(m_read), 32'h0);
    check("t4b_m_data", m_data_in, 32'hBEEF_0002);
    check("t4b_ack_once", 32'(req_ack), 32'h0);
    repeat (3) begin
      @(negedge clk); #1;
      check("t4b_no_resp", 32'(resp_valid), 32'h0);
    end
    // Pointer held at 0 through the idle cycles.
    drive(0, 1'b1, 1'b0, 2'd0, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd0, 32'h0);
    #1 check("t4b_ptr_hold", 32'(req_ack), 32'h1);
    idle();

    // 5: master 1 writes addr 3, master 0 reads it back next cycle.
    do_reset();
    drive(1, 1'b0, 1'b1, 2'd3, 32'h0000_1234);
    #1 check("t5_ack_w", 32'(req_ack), 32'h2);
    @(negedge clk);
    idle();
    drive(0, 1'b1, 1'b0, 2'd3, 32'h0);
    #1;
    check("t5_ack_r", 32'(req_ack), 32'h1);
    check("t5_m_write", 32'(m_write), 32'h1);
    check("t5_m_data", m_data_in, 32'h0000_1234);
    @(negedge clk); idle(); #1;
    check("t5_m_read", 32'(m_read), 32'h1);
    @(negedge clk); #1;
    check("t5_resp_early", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("t5_resp_valid", 32'(resp_valid), 32'h1);
    check("t5_resp_data", resp_data, 32'h0000_1234);
    check("t5_perr_clean", 32'(protocol_error), 32'h0);

    // 6: reset kills the in-flight read; a stray m_read_valid flags an error.
    do_reset();
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0);
    #1 check("t6_ack", 32'(req_ack), 32'h1);
    @(negedge clk); idle(); #1;
    check("t6_m_read", 32'(m_read), 32'h1);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check("t6_m_read_cleared", 32'(m_read), 32'h0);
    check("t6_resp_none", 32'(resp_valid), 32'h0);
    check("t6_perr_before", 32'(protocol_error), 32'h0);
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    #1;
    check("t6_perr_set", 32'(protocol_error), 32'h1);
    check("t6_resp_dropped", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("t6_perr_sticky", 32'(protocol_error), 32'h1);
    check("t6_resp_still_none", 32'(resp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
